run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_pkg.sv | 20 ++
 rtl/sat_counter.sv | 39 +++
 rtl/run_ctrl.sv | 143 ++++++++++++++
 tb/tb_run_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and parameter defaults for the run controller.
//   state_e       - controller FSM states
//   CwDefault     - default width of the RUN cycle counter / cycles output
//   TmoDefault    - default RUN-cycle budget before a timeout is declared
//   RstLenDefault - default number of cycles core_rst is held per launch
package run_ctrl_pkg;

  localparam int unsigned CwDefault     = 16;
  localparam int unsigned TmoDefault    = 1000;
  localparam int unsigned RstLenDefault = 2;

  typedef enum logic [2:0] {
    StIdle,
    StRst,
    StReq,
    StRun,
    StFin
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: CW-bit up counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset, clears the count
//   clear  - synchronous clear, takes priority over enable
//   enable - increment by one this cycle (ignored once saturated)
//   count  - current count value
module sat_counter #(
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != {CW{1'b1}})) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: launches a processor core (reset pulse, then a one-cycle request), measures how many
// cycles the core runs until it reports done, and declares a timeout if it runs too long.
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-low reset
//   start     - launch request, only looked at while idle
//   abort     - cancel; returns to idle from any active state without a fin pulse
//   core_done - completion level from the core, only looked at while running
//   core_rst  - reset to the core, high for RST_LEN cycles per launch
//   core_req  - one-cycle start request to the core
//   busy      - high whenever not idle
//   fin       - one-cycle pulse at the end of a completed or timed-out run
//   timed_out - sticky timeout flag, cleared by the next accepted start
//   cycles    - RUN-cycle count of the last finished run (TMO on timeout)
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned CW      = CwDefault,
  parameter int unsigned TMO     = TmoDefault,
  parameter int unsigned RST_LEN = RstLenDefault
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          core_done,
  output logic          core_rst,
  output logic          core_req,
  output logic          busy,
  output logic          fin,
  output logic          timed_out,
  output logic [CW-1:0] cycles
);

  localparam logic [CW-1:0] TmoLast = CW'(TMO - 1);
  localparam logic [CW-1:0] TmoVal  = CW'(TMO);
  localparam logic [3:0]    RstLast = 4'(RST_LEN - 1);

  state_e        state_q, state_d;
  logic [3:0]    rst_cnt_q, rst_cnt_d;
  logic          timed_out_q, timed_out_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic          core_rst_q, core_req_q, busy_q, fin_q;

  logic          cnt_clear, cnt_en;
  logic [CW-1:0] cnt;

  sat_counter #(
    .CW (CW)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (cnt)
  );

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    timed_out_d = timed_out_q;
    cycles_d    = cycles_q;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;

    if (abort && (state_q != StIdle)) begin
      // Cancel leaves cycles and timed_out exactly as they were.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && !abort) begin
            state_d     = StRst;
            rst_cnt_d   = '0;
            timed_out_d = 1'b0;
            cnt_clear   = 1'b1;
          end
        end
        StRst: begin
          if (rst_cnt_q == RstLast) begin
            state_d = StReq;
          end else begin
            rst_cnt_d = rst_cnt_q + 4'd1;
          end
        end
        StReq: begin
          state_d = StRun;
        end
        StRun: begin
          // Done is checked first so it beats a timeout in the same cycle.
          if (core_done) begin
            cycles_d = cnt;
            state_d  = StFin;
          end else begin
            cnt_en = 1'b1;
            if (cnt == TmoLast) begin
              timed_out_d = 1'b1;
              cycles_d    = TmoVal;
              state_d     = StFin;
            end
          end
        end
        StFin: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rst_cnt_q   <= '0;
      timed_out_q <= 1'b0;
      cycles_q    <= '0;
      core_rst_q  <= 1'b0;
      core_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      timed_out_q <= timed_out_d;
      cycles_q    <= cycles_d;
      core_rst_q  <= (state_d == StRst);
      core_req_q  <= (state_d == StReq);
      busy_q      <= (state_d != StIdle);
      fin_q       <= (state_d == StFin);
    end
  end

  assign core_rst  = core_rst_q;
  assign core_req  = core_req_q;
  assign busy      = busy_q;
  assign fin       = fin_q;
  assign timed_out = timed_out_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl. Three instances with different parameters share clock and reset.
// Expected outputs come from a launch timeline computed with arithmetic from the run
// parameters (reset length, timeout, when done rises, when abort fires).
module tb_run_ctrl;

  logic clk;
  logic rst_n;
  logic start_v [3];
  logic abort_v [3];
  logic done_v  [3];
  logic rst_v   [3];
  logic req_v   [3];
  logic busy_v  [3];
  logic fin_v   [3];
  logic to_v    [3];
  logic [15:0] cyc_v [2];
  logic [3:0]  cyc2;

  int n_vec = 0;
  int n_err = 0;

  int          rl_p  [3] = '{2, 3, 1};
  int          tmo_p [3] = '{1000, 8, 15};
  logic [15:0] cyc_m [3];
  logic        to_m  [3];

  run_ctrl #(.CW(16), .TMO(1000), .RST_LEN(2)) u_dut0 (
    .clk(clk), .reset(rst_n), .start(start_v[0]), .abort(abort_v[0]), .core_done(done_v[0]),
    .core_rst(rst_v[0]), .core_req(req_v[0]), .busy(busy_v[0]), .fin(fin_v[0]),
    .timed_out(to_v[0]), .cycles(cyc_v[0])
  );

  run_ctrl #(.CW(16), .TMO(8), .RST_LEN(3)) u_dut1 (
    .clk(clk), .reset(rst_n), .start(start_v[1]), .abort(abort_v[1]), .core_done(done_v[1]),
    .core_rst(rst_v[1]), .core_req(req_v[1]), .busy(busy_v[1]), .fin(fin_v[1]),
    .timed_out(to_v[1]), .cycles(cyc_v[1])
  );

  run_ctrl #(.CW(4), .TMO(15), .RST_LEN(1)) u_dut2 (
    .clk(clk), .reset(rst_n), .start(start_v[2]), .abort(abort_v[2]), .core_done(done_v[2]),
    .core_rst(rst_v[2]), .core_req(req_v[2]), .busy(busy_v[2]), .fin(fin_v[2]),
    .timed_out(to_v[2]), .cycles(cyc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] obs_cyc(input int w);
    case (w)
      0:       return cyc_v[0];
      1:       return cyc_v[1];
      default: return {12'b0, cyc2};
    endcase
  endfunction

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check(input int w, input string tag, input logic e_rst, input logic e_req,
                       input logic e_busy, input logic e_fin);
    cmp($sformatf("%s_u%0d_core_rst", tag, w), {15'b0, rst_v[w]}, {15'b0, e_rst});
    cmp($sformatf("%s_u%0d_core_req", tag, w), {15'b0, req_v[w]}, {15'b0, e_req});
    cmp($sformatf("%s_u%0d_busy", tag, w), {15'b0, busy_v[w]}, {15'b0, e_busy});
    cmp($sformatf("%s_u%0d_fin", tag, w), {15'b0, fin_v[w]}, {15'b0, e_fin});
    cmp($sformatf("%s_u%0d_timed_out", tag, w), {15'b0, to_v[w]}, {15'b0, to_m[w]});
    cmp($sformatf("%s_u%0d_cycles", tag, w), obs_cyc(w), cyc_m[w]);
  endtask

  // One launch attempt on instance w. Edge 0 is the edge that samples start.
  // done_start_e: first edge index at which core_done is high (held afterwards).
  // abort_e: edge index at which abort is high for one cycle, or -1 for none.
  task automatic run(input int w, input int done_start_e, input int abort_e,
                     input bit rand_start, input string tag);
    int  rl, tm, done_j, fin_e, stop_e;
    bit  launched, aborted, done_won;
    rl       = rl_p[w];
    tm       = tmo_p[w];
    done_j   = done_start_e - rl - 1;           // first RUN cycle (1-based) seeing done
    if (done_j < 1) done_j = 1;
    done_won = (done_j <= tm);
    fin_e    = rl + 1 + (done_won ? done_j : tm);
    launched = (abort_e != 0);
    aborted  = launched && (abort_e >= 1) && (abort_e <= fin_e);
    stop_e   = !launched ? 0 : (aborted ? abort_e : fin_e + 1);
    for (int e = 0; e <= stop_e + 1; e++) begin
      start_v[w] = (e == 0) ||
                   (rand_start && (e <= stop_e) && ($urandom_range(1) == 1));
      abort_v[w] = (e == abort_e);
      done_v[w]  = (e >= done_start_e);
      @(posedge clk);
      #1;
      if (launched && e == 0) to_m[w] = 1'b0;
      if (launched && !aborted && e == fin_e) begin
        cyc_m[w] = done_won ? 16'(done_j - 1) : 16'(tm);
        to_m[w]  = !done_won;
      end
      check(w, $sformatf("%s_e%0d", tag, e),
            launched && (e < stop_e) && (e < rl),
            launched && (e < stop_e) && (e == rl),
            launched && (e < stop_e),
            launched && !aborted && (e == fin_e));
    end
    start_v[w] = 1'b0;
    abort_v[w] = 1'b0;
    done_v[w]  = 1'b0;
  endtask

  initial begin
    int w, ds, ab;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
      done_v[i]  = 1'b0;
      cyc_m[i]   = '0;
      to_m[i]    = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check(i, "reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(0, 0, -1, 1'b0, "stale");            // done held high from launch
    run(0, 2 + 1 + 37, -1, 1'b0, "normal");  // done on 37th RUN cycle -> 36
    run(0, 100, 2 + 1 + 6, 1'b0, "abort5");  // abort while counter is 5
    run(0, 5, 0, 1'b0, "start_abort");       // start and abort together in idle
    run(0, 10, 2, 1'b0, "abort_rst");        // abort during core reset
    run(1, 1000, -1, 1'b0, "timeout");
    run(1, 3 + 1 + 3, -1, 1'b0, "clear_to");
    run(1, 1000, -1, 1'b1, "timeout2");
    run(1, 3 + 1 + 8, -1, 1'b0, "tie");      // done and timeout in the same cycle
    run(2, 1000, -1, 1'b0, "sat");           // CW=4 timeout at the all-ones count
    run(2, 1 + 1 + 16, -1, 1'b0, "sat_late");

    // Asynchronous reset while instance 0 is in its core-reset phase.
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    to_m[0] = 1'b0;
    check(0, "pre_arst", 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc_m[i] = '0;
      to_m[i]  = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) check(i, "arst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(0, 2 + 1 + 11, -1, 1'b0, "post_arst");

    for (int k = 0; k < 30; k++) begin
      w  = int'($urandom_range(2));
      ds = int'($urandom_range(25));
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(20)) : -1;
      run(w, ds, ab, 1'b1, $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
